vga_timing_gen: RTL

Parametrised raster timing generator for the video pipeline. It replaces the fixed 1024x768@60 XGA timing block with one whose active area, porches, sync widths and sync polarities are all parameters. It adds a pixel-clock enable, a registered display-enable, and single-cycle line/frame start strobes. Downstream drawing and memory-fetch blocks consume its counters and flags unchanged.

---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 91 +++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, counters, levels and strobes out.
interface vga_timing_gen_if #(
  parameter int CW = 11
) ();
  logic          ce;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblnk;
  logic          vblnk;
  logic          de;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, blanking, sync, display
// enable and line/frame start strobes, all advancing on ce.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 11
) (
  input  logic pclk,
  input  logic rst,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_check
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an end bound equal to 2**CW stays exact.
  localparam logic [CW:0] HB_START = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_START = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VB_START = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_START = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, v_q, h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          hb_nxt, vb_nxt, hs_nxt, vs_nxt;
  logic          hb_q, vb_q, hs_q, vs_q, de_q, ls_q, fs_q;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_nxt  = h_wrap ? '0 : h_q + CW'(1);
    v_nxt  = v_q;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_q + CW'(1);
    hb_nxt = ({1'b0, h_nxt} >= HB_START);
    vb_nxt = ({1'b0, v_nxt} >= VB_START);
    hs_nxt = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
    vs_nxt = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
  end

  // Levels are computed from the next position so they line up with the counters.
  always_ff @(posedge pclk) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      hb_q <= 1'b0;
      vb_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= vid.ce & h_wrap;
      fs_q <= vid.ce & h_wrap & v_wrap;
      if (vid.ce) begin
        h_q  <= h_nxt;
        v_q  <= v_nxt;
        hb_q <= hb_nxt;
        vb_q <= vb_nxt;
        hs_q <= hs_nxt ? HS_POL : ~HS_POL;
        vs_q <= vs_nxt ? VS_POL : ~VS_POL;
        de_q <= ~hb_nxt & ~vb_nxt;
      end
    end
  end

  assign vid.hcount      = h_q;
  assign vid.vcount      = v_q;
  assign vid.hblnk       = hb_q;
  assign vid.vblnk       = vb_q;
  assign vid.hsync       = hs_q;
  assign vid.vsync       = vs_q;
  assign vid.de          = de_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;
endmodule
